npu_input_sequencer: RTL and testbench

- Sits directly downstream of npu_input_interface; drains its 16-bit FIFO output and delivers framed operand vectors to the NPU PE array.
- Configured by one 16-bit word: vector length N and vector count M.
- Tags every word with first/last markers, absorbs PE backpressure with a 2-entry output buffer, and signals completion.

---
 rtl/npu_input_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_npu_input_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_input_sequencer.sv
// Input sequencer: drains the input-interface FIFO and delivers framed operand
// vectors (first/last tags) to the PE array through a 2-entry skid buffer.
module npu_input_sequencer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_en,
    input  logic [15:0]       cfg_data,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_read_en,
    output logic [DATA_W-1:0] pe_data,
    output logic              pe_valid,
    output logic              pe_first,
    output logic              pe_last,
    input  logic              pe_ready,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    localparam int unsigned SLOTS = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              first;
        logic              last;
    } beat_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  n_q, m_q, elem_q, vec_q;
    logic              inflight_q, inf_first_q, inf_last_q;
    beat_t             slot0_q, slot1_q;
    logic              vld0_q, vld1_q;
    logic              busy_q, done_q, cfg_err_q;

    logic              issue, load_cfg, done_d, cfg_err_d;
    logic              credit_ok, elem_last, pop, cap;
    logic [1:0]        credits;
    logic [LEN_W-1:0]  cfg_n, cfg_m;
    beat_t             cap_beat;

    assign cfg_n     = cfg_data[LEN_W-1:0];
    assign cfg_m     = cfg_data[2*LEN_W-1:LEN_W];
    assign elem_last = (elem_q == n_q - LEN_W'(1));

    // Credit check on registered occupancy only: buffered + in-flight never exceeds the slots.
    assign credits   = 2'(vld0_q) + 2'(vld1_q) + 2'(inflight_q);
    assign credit_ok = !fifo_empty && (credits < 2'(SLOTS));

    assign pop      = vld0_q && pe_ready;
    assign cap      = inflight_q;
    assign cap_beat = '{data: fifo_data, first: inf_first_q, last: inf_last_q};

    assign fifo_read_en = issue;
    assign pe_data      = slot0_q.data;
    assign pe_first     = slot0_q.first;
    assign pe_last      = slot0_q.last;
    assign pe_valid     = vld0_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign cfg_err      = cfg_err_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, read issue and pulse requests
    always_comb begin
        state_d   = state_q;
        issue     = 1'b0;
        load_cfg  = 1'b0;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_en) begin
                    if (cfg_n != '0) begin
                        load_cfg = 1'b1;
                        state_d  = RUN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                cfg_err_d = cfg_en;
                issue     = credit_ok;
                if (issue && elem_last && (m_q != '0) && (vec_q == m_q - LEN_W'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                cfg_err_d = cfg_en;
                if (!vld0_q && !inflight_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Configuration and element/vector counters; tags are fixed at issue time
    always_ff @(posedge clk) begin
        if (rst) begin
            n_q         <= '0;
            m_q         <= '0;
            elem_q      <= '0;
            vec_q       <= '0;
            inflight_q  <= 1'b0;
            inf_first_q <= 1'b0;
            inf_last_q  <= 1'b0;
        end else begin
            if (load_cfg) begin
                n_q    <= cfg_n;
                m_q    <= cfg_m;
                elem_q <= '0;
                vec_q  <= '0;
            end else if (issue) begin
                if (elem_last) begin
                    elem_q <= '0;
                    vec_q  <= vec_q + LEN_W'(1);
                end else begin
                    elem_q <= elem_q + LEN_W'(1);
                end
            end
            inflight_q  <= issue;
            inf_first_q <= (elem_q == '0);
            inf_last_q  <= elem_last;
        end
    end

    // Two-slot in-order output buffer; slot0 is the head
    always_ff @(posedge clk) begin
        if (rst) begin
            slot0_q <= '0;
            slot1_q <= '0;
            vld0_q  <= 1'b0;
            vld1_q  <= 1'b0;
        end else begin
            case ({cap, pop})
                2'b11: begin
                    if (vld1_q) begin
                        slot0_q <= slot1_q;
                        slot1_q <= cap_beat;
                    end else begin
                        slot0_q <= cap_beat;
                    end
                end
                2'b01: begin
                    slot0_q <= slot1_q;
                    vld0_q  <= vld1_q;
                    vld1_q  <= 1'b0;
                end
                2'b10: begin
                    if (!vld0_q) begin
                        slot0_q <= cap_beat;
                        vld0_q  <= 1'b1;
                    end else begin
                        slot1_q <= cap_beat;
                        vld1_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            busy_q    <= (state_d != IDLE);
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_npu_input_sequencer.sv
// Bench for npu_input_sequencer: FIFO model, scoreboard of tagged beats,
// scenario table plus hand-written reset and reconfiguration sequences.
module tb_npu_input_sequencer;

    localparam int unsigned DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_en = 1'b0;
    logic [15:0]       cfg_data = '0;
    logic              fifo_empty = 1'b1;
    logic [DATA_W-1:0] fifo_data = '0;
    logic              fifo_read_en;
    logic [DATA_W-1:0] pe_data;
    logic              pe_valid, pe_first, pe_last;
    logic              pe_ready = 1'b0;
    logic              busy, done, cfg_err;

    npu_input_sequencer #(.DATA_W(DATA_W), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_data(cfg_data),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_read_en(fifo_read_en),
        .pe_data(pe_data), .pe_valid(pe_valid), .pe_first(pe_first), .pe_last(pe_last),
        .pe_ready(pe_ready), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              first;
        logic              last;
    } beat_t;

    typedef struct {
        logic [15:0] cfg;
        int          nwords;
        int          ready_mode;   // 0 always, 1 toggle 1-0-0-1, 2 random
        int          gap_after;    // 0 = FIFO preloaded with everything
        int          exp_err;
        int          exp_done;
        int          exp_busy;
    } scn_t;

    beat_t       exp_q[$];
    logic [15:0] fifo_q[$];
    int total = 0, passed = 0;
    int cyc = 0, reads = 0, pops = 0, tag_k = 0;
    int done_cnt = 0, err_cnt = 0, beats = 0, first_read = -1, first_valid = -1;
    int ready_mode = 3;
    logic busy_seen = 1'b0, prev_stall = 1'b0;
    beat_t prev_beat = '0;
    logic [3:0] ready_pat = 4'b1001;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Upstream FIFO model and read-legality checks at the active edge
    always @(posedge clk) begin
        cyc++;
        if (fifo_read_en) begin
            if (!rst) begin
                check("read_while_empty", 64'(fifo_q.size() != 0), 64'd1);
                check("read_over_credit", 64'((reads - pops) < 2), 64'd1);
            end
            if (fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
            reads++;
        end
        if (pe_valid && pe_ready) pops++;
        if (rst) begin
            reads = 0;
            pops  = 0;
        end
    end

    always begin
        @(posedge clk);
        #2;
        fifo_empty = (fifo_q.size() == 0);
    end

    always begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       pe_ready = 1'b1;
            1:       pe_ready = ready_pat[cyc % 4];
            2:       pe_ready = 1'(($urandom_range(0, 1)));
            default: pe_ready = 1'b0;
        endcase
    end

    // Output monitor: scoreboard pops, stall stability, pulse counting
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (cfg_err) err_cnt++;
            if (busy) busy_seen = 1'b1;
            if (fifo_read_en && first_read < 0) first_read = cyc;
            if (pe_valid && first_valid < 0) first_valid = cyc;
            if (prev_stall)
                check("stall_hold", 64'({pe_valid, pe_data, pe_first, pe_last}), 64'({1'b1, prev_beat}));
            if (pe_valid && pe_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(pe_data), 64'hFFFF_FFFF);
                end else begin
                    check("beat", 64'({pe_data, pe_first, pe_last}), 64'(exp_q.pop_front()));
                    beats++;
                end
            end
            prev_stall = pe_valid && !pe_ready;
            prev_beat  = {pe_data, pe_first, pe_last};
        end
    end

    task automatic clear_counts();
        done_cnt = 0; err_cnt = 0; beats = 0; tag_k = 0;
        first_read = -1; first_valid = -1; busy_seen = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1; cfg_en = 1'b0;
        exp_q.delete(); fifo_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        clear_counts();
    endtask

    task automatic check_reset_outputs(input string name);
        @(negedge clk);
        check(name, 64'({pe_data, pe_valid, pe_first, pe_last, busy, done, cfg_err, fifo_read_en}), 64'd0);
    endtask

    task automatic pulse_cfg(input logic [15:0] v);
        @(posedge clk); #1;
        cfg_en = 1'b1; cfg_data = v;
        @(posedge clk); #1;
        cfg_en = 1'b0;
    endtask

    task automatic push_word(input logic [15:0] d, input int n);
        logic f, l;
        f = ((tag_k % n) == 0);
        l = ((tag_k % n) == n - 1);
        tag_k++;
        fifo_q.push_back(d);
        exp_q.push_back({d, f, l});
    endtask

    task automatic wait_end(input int want_done);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (want_done != 0 ? done_cnt != 0 : exp_q.size() == 0) break;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run_scn(input int idx, input scn_t s);
        int n;
        apply_reset();
        ready_mode = s.ready_mode;
        n = int'(s.cfg[7:0]);
        @(posedge clk); #1;
        for (int i = 0; i < s.nwords && (s.gap_after == 0 || i < s.gap_after); i++)
            push_word(16'(i + 1), n);
        pulse_cfg(s.cfg);
        if (s.gap_after != 0) begin
            for (int i = 0; i < 200 && fifo_q.size() != 0; i++) @(posedge clk);
            check($sformatf("scn%0d_gap_drain", idx), 64'(fifo_q.size()), 64'd0);
            repeat (10) @(posedge clk);
            #1;
            for (int i = s.gap_after; i < s.nwords; i++) push_word(16'(i + 1), n);
        end
        wait_end(s.exp_done);
        check($sformatf("scn%0d_done", idx), 64'(done_cnt), 64'(s.exp_done));
        check($sformatf("scn%0d_cfg_err", idx), 64'(err_cnt), 64'(s.exp_err));
        check($sformatf("scn%0d_beats", idx), 64'(beats), 64'(s.nwords));
        check($sformatf("scn%0d_leftover", idx), 64'(exp_q.size()), 64'd0);
        check($sformatf("scn%0d_busy_end", idx), 64'(busy), 64'(s.exp_busy));
        if (s.nwords > 0)
            check($sformatf("scn%0d_latency", idx), 64'(first_valid - first_read), 64'd2);
        else
            check($sformatf("scn%0d_busy_seen", idx), 64'(busy_seen), 64'd0);
    endtask

    initial begin
        scn_t tbl[6];
        tbl[0] = '{cfg: 16'h0304, nwords: 12, ready_mode: 0, gap_after: 0, exp_err: 0, exp_done: 1, exp_busy: 0};
        tbl[1] = '{cfg: 16'h0304, nwords: 12, ready_mode: 1, gap_after: 0, exp_err: 0, exp_done: 1, exp_busy: 0};
        tbl[2] = '{cfg: 16'h0304, nwords: 12, ready_mode: 0, gap_after: 5, exp_err: 0, exp_done: 1, exp_busy: 0};
        tbl[3] = '{cfg: 16'h0500, nwords: 0,  ready_mode: 0, gap_after: 0, exp_err: 1, exp_done: 0, exp_busy: 0};
        tbl[4] = '{cfg: 16'h0201, nwords: 2,  ready_mode: 0, gap_after: 0, exp_err: 0, exp_done: 1, exp_busy: 0};
        tbl[5] = '{cfg: 16'h0002, nwords: 6,  ready_mode: 2, gap_after: 0, exp_err: 0, exp_done: 0, exp_busy: 1};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_outputs("reset_state");

        for (int i = 0; i < 6; i++) run_scn(i, tbl[i]);

        // Reconfiguration attempt while streaming is rejected and harmless
        apply_reset();
        ready_mode = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) push_word(16'(i + 1), 4);
        pulse_cfg(16'h0304);
        repeat (4) @(posedge clk);
        pulse_cfg(16'h0102);
        wait_end(1);
        check("run_cfg_err", 64'(err_cnt), 64'd1);
        check("run_cfg_done", 64'(done_cnt), 64'd1);
        check("run_cfg_beats", 64'(beats), 64'd12);

        // Reset with a read in flight, then a clean restart
        apply_reset();
        ready_mode = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) push_word(16'(i + 1), 4);
        pulse_cfg(16'h0304);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (first_valid >= 0 && fifo_read_en) break;
        end
        check("rst_setup_inflight", 64'(fifo_read_en), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete(); fifo_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        clear_counts();
        check_reset_outputs("rst_mid_outputs");
        repeat (3) @(negedge clk);
        check("rst_no_stray", 64'(pe_valid), 64'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) push_word(16'(100 + i), 3);
        pulse_cfg(16'h0203);
        wait_end(1);
        check("restart_done", 64'(done_cnt), 64'd1);
        check("restart_beats", 64'(beats), 64'd6);
        check("restart_leftover", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
